sdram_arbit: RTL and testbench

// - Sits between the SDRAM controller top and the chip pins. Owns init hand-off, the refresh timer and auto-refresh sequencing.
// - Arbitrates the write and read engines via req/en/end handshakes. Priority: refresh > write > read.
// - Muxes the granted engine's cmd/addr/bank/data onto the SDRAM bus.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_arbit_if.sv | 57 +++++
 rtl/sdram_aref.sv | 61 ++++++
 rtl/sdram_arbit.sv | 102 ++++++++++
 tb/tb_sdram_arbit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command codes, arbiter state encodings and timing defaults.
// Shared by the arbiter, its refresh sub-block and the interface users.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  // One-hot state bit positions
  localparam int I_INIT  = 0;
  localparam int I_ARBIT = 1;
  localparam int I_AREF  = 2;
  localparam int I_WRITE = 3;
  localparam int I_READ  = 4;

  localparam logic [4:0] S_INIT  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;

  localparam int REF_PERIOD_DEF = 750;
  localparam int T_RFC_DEF      = 7;

endpackage

// File: rtl/sdram_arbit_if.sv
// sdram_arbit_if: engine handshakes, engine buses and SDRAM pin bundle.
// slave = arbiter view, master = engines/pins view.
interface sdram_arbit_if;

  logic        flag_init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;

  logic        wr_req;
  logic        wr_en;
  logic        flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [15:0] wr_data;

  logic        rd_req;
  logic        rd_en;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;

  logic        ref_req;

  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  modport slave (
    input  flag_init_end, init_cmd, init_addr,
    input  wr_req, flag_wr_end, wr_cmd,
    input  wr_addr, wr_bank, wr_data,
    input  rd_req, flag_rd_end, rd_cmd,
    input  rd_addr, rd_bank,
    output wr_en, rd_en, ref_req,
    output sdram_cke, sdram_cmd, sdram_addr,
    output sdram_bank, sdram_dq_out,
    output sdram_dq_oe
  );

  modport master (
    output flag_init_end, init_cmd, init_addr,
    output wr_req, flag_wr_end, wr_cmd,
    output wr_addr, wr_bank, wr_data,
    output rd_req, flag_rd_end, rd_cmd,
    output rd_addr, rd_bank,
    input  wr_en, rd_en, ref_req,
    input  sdram_cke, sdram_cmd, sdram_addr,
    input  sdram_bank, sdram_dq_out,
    input  sdram_dq_oe
  );

endinterface

// File: rtl/sdram_aref.sv
// sdram_aref: refresh interval timer, ref_req flag and AREF sequencing.
// Ports: aref_start (in AREF state), init_done -> ref_req, flag_ref_end, aref_cmd.
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int T_RFC      = T_RFC_DEF
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       aref_start,
  input  logic       init_done,
  output logic       ref_req,
  output logic       flag_ref_end,
  output logic [3:0] aref_cmd
);

  logic [9:0] ref_cnt;
  logic [3:0] aref_cnt;
  logic       wrap;
  logic       aref_first;

  assign wrap = init_done &&
    (ref_cnt == 10'(REF_PERIOD - 1));
  assign aref_first = aref_start &&
    (aref_cnt == 4'd0);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      ref_cnt <= '0;
    else if (!init_done || wrap)
      ref_cnt <= '0;
    else
      ref_cnt <= ref_cnt + 10'd1;
  end

  // A wrap wins over the clear so a request
  // landing on the AREF entry cycle survives.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      ref_req <= 1'b0;
    else if (wrap)
      ref_req <= 1'b1;
    else if (aref_first)
      ref_req <= 1'b0;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      aref_cnt <= '0;
    else if (!aref_start)
      aref_cnt <= '0;
    else
      aref_cnt <= aref_cnt + 4'd1;
  end

  assign flag_ref_end = aref_start &&
    (aref_cnt == 4'(T_RFC));
  assign aref_cmd = aref_first ? CMD_AREF : CMD_NOP;

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: init hand-off, refresh > write > read arbitration, pin mux.
// Ports: sclk, s_rst_n, bus (sdram_arbit_if.slave: engines + SDRAM pins).
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int T_RFC      = T_RFC_DEF
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  sdram_arbit_if.slave  bus
);

  logic [4:0] state;
  logic [4:0] nxt;
  logic       ref_req;
  logic       flag_ref_end;
  logic [3:0] aref_cmd;
  logic       wr_en;
  logic       rd_en;

  sdram_aref #(
    .REF_PERIOD (REF_PERIOD),
    .T_RFC      (T_RFC)
  ) u_aref (
    .sclk         (sclk),
    .s_rst_n      (s_rst_n),
    .aref_start   (state[I_AREF]),
    .init_done    (!state[I_INIT]),
    .ref_req      (ref_req),
    .flag_ref_end (flag_ref_end),
    .aref_cmd     (aref_cmd)
  );

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[I_INIT]:
        if (bus.flag_init_end) nxt = S_ARBIT;
      state[I_ARBIT]:
        if (ref_req)         nxt = S_AREF;
        else if (bus.wr_req) nxt = S_WRITE;
        else if (bus.rd_req) nxt = S_READ;
      state[I_AREF]:
        if (flag_ref_end) nxt = S_ARBIT;
      state[I_WRITE]:
        if (bus.flag_wr_end) nxt = S_ARBIT;
      state[I_READ]:
        if (bus.flag_rd_end) nxt = S_ARBIT;
      default:
        nxt = S_INIT;
    endcase
  end

  // Grants pulse only on entry: the engine may
  // re-request in the cycle it releases the bus.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= S_INIT;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      state <= nxt;
      wr_en <= state[I_ARBIT] && nxt[I_WRITE];
      rd_en <= state[I_ARBIT] && nxt[I_READ];
    end
  end

  always_comb begin
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_addr = '0;
    bus.sdram_bank = '0;
    unique case (1'b1)
      state[I_INIT]: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      state[I_AREF]: begin
        bus.sdram_cmd  = aref_cmd;
      end
      state[I_WRITE]: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_bank = bus.wr_bank;
      end
      state[I_READ]: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_bank = bus.rd_bank;
      end
      default: ;
    endcase
  end

  assign bus.wr_en        = wr_en;
  assign bus.rd_en        = rd_en;
  assign bus.ref_req      = ref_req;
  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_dq_oe  = state[I_WRITE];
  assign bus.sdram_dq_out = bus.wr_data;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed phases plus random engine traffic for sdram_arbit.
// Outputs are checked every cycle against a bus-ownership reference model.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int M_INIT = 0;
  localparam int M_IDLE = 1;
  localparam int M_REF  = 2;
  localparam int M_WR   = 3;
  localparam int M_RD   = 4;
  localparam int RP     = 750;
  localparam int TRFC   = 7;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;

  sdram_arbit_if bus();

  sdram_arbit dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, refresh
  // pending flag, elapsed cycles since init.
  int owner;
  int elapsed;
  int ref_age;
  bit pend;
  bit exp_wen;
  bit exp_ren;

  int wr_left;
  int rd_left;
  int aref_seen;
  int wr_grants;
  int rd_grants;
  int guard;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner   = M_INIT;
    elapsed = 0;
    ref_age = 0;
    pend    = 1'b0;
    exp_wen = 1'b0;
    exp_ren = 1'b0;
  endtask

  // Applies one clock edge using the inputs
  // that were stable before it.
  task automatic model_step();
    int  nxt;
    bit  tick;
    nxt  = owner;
    tick = (owner != M_INIT) &&
           (elapsed % RP == RP - 1);
    case (owner)
      M_INIT: if (bus.flag_init_end) nxt = M_IDLE;
      M_IDLE: begin
        if (pend)            nxt = M_REF;
        else if (bus.wr_req) nxt = M_WR;
        else if (bus.rd_req) nxt = M_RD;
      end
      M_REF: if (ref_age == TRFC) nxt = M_IDLE;
      M_WR:  if (bus.flag_wr_end) nxt = M_IDLE;
      M_RD:  if (bus.flag_rd_end) nxt = M_IDLE;
      default: nxt = M_INIT;
    endcase
    exp_wen = (owner == M_IDLE) && (nxt == M_WR);
    exp_ren = (owner == M_IDLE) && (nxt == M_RD);
    if (tick) pend = 1'b1;
    else if (owner == M_REF && ref_age == 0)
      pend = 1'b0;
    elapsed = (owner == M_INIT) ? 0 : elapsed + 1;
    ref_age = (owner == M_REF && nxt == M_REF) ?
              ref_age + 1 : 0;
    owner = nxt;
  endtask

  task automatic check_all();
    logic [3:0]  ec;
    logic [12:0] ea;
    logic [1:0]  eb;
    ec = CMD_NOP;
    ea = '0;
    eb = '0;
    case (owner)
      M_INIT: begin
        ec = bus.init_cmd;
        ea = bus.init_addr;
      end
      M_REF: ec = (ref_age == 0) ? CMD_AREF : CMD_NOP;
      M_WR: begin
        ec = bus.wr_cmd;
        ea = bus.wr_addr;
        eb = bus.wr_bank;
      end
      M_RD: begin
        ec = bus.rd_cmd;
        ea = bus.rd_addr;
        eb = bus.rd_bank;
      end
      default: ;
    endcase
    chk("cmd",    32'(bus.sdram_cmd),    32'(ec));
    chk("addr",   32'(bus.sdram_addr),   32'(ea));
    chk("bank",   32'(bus.sdram_bank),   32'(eb));
    chk("wr_en",  32'(bus.wr_en),        32'(exp_wen));
    chk("rd_en",  32'(bus.rd_en),        32'(exp_ren));
    chk("ref_req",32'(bus.ref_req),      32'(pend));
    chk("dq_oe",  32'(bus.sdram_dq_oe),  32'(owner == M_WR));
    chk("dq_out", 32'(bus.sdram_dq_out), 32'(bus.wr_data));
    chk("cke",    32'(bus.sdram_cke),    32'd1);
    if (owner != M_INIT && bus.sdram_cmd === CMD_AREF)
      aref_seen++;
    if (bus.wr_en === 1'b1) wr_grants++;
    if (bus.rd_en === 1'b1) rd_grants++;
  endtask

  task automatic cycle();
    @(posedge sclk);
    model_step();
    #1;
    check_all();
    @(negedge sclk);
  endtask

  // Engine emulation: random buses, release
  // a few cycles after each grant.
  task automatic drive(input bit rnd);
    bus.init_cmd  = 4'($urandom);
    bus.init_addr = 13'($urandom);
    bus.wr_cmd    = 4'($urandom);
    bus.wr_addr   = 13'($urandom);
    bus.wr_bank   = 2'($urandom);
    bus.wr_data   = 16'($urandom);
    bus.rd_cmd    = 4'($urandom);
    bus.rd_addr   = 13'($urandom);
    bus.rd_bank   = 2'($urandom);
    bus.flag_wr_end = 1'b0;
    bus.flag_rd_end = 1'b0;
    if (wr_left > 0) begin
      wr_left--;
      if (wr_left == 0) bus.flag_wr_end = 1'b1;
    end
    if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0) bus.flag_rd_end = 1'b1;
    end
    if (exp_wen) begin
      wr_left = int'($urandom_range(1, 6));
      if (!rnd) bus.wr_req = 1'b0;
    end
    if (exp_ren) begin
      rd_left = int'($urandom_range(1, 6));
      if (!rnd) bus.rd_req = 1'b0;
    end
    if (rnd) begin
      if ($urandom_range(0, 5) == 0)
        bus.wr_req = ~bus.wr_req;
      if ($urandom_range(0, 5) == 0)
        bus.rd_req = ~bus.rd_req;
    end
  endtask

  task automatic apply_reset(input int n);
    s_rst_n = 1'b0;
    model_reset();
    wr_left = 0;
    rd_left = 0;
    bus.flag_init_end = 1'b0;
    bus.wr_req      = 1'b0;
    bus.rd_req      = 1'b0;
    bus.flag_wr_end = 1'b0;
    bus.flag_rd_end = 1'b0;
    bus.init_cmd    = CMD_NOP;
    bus.init_addr   = '0;
    #1;
    check_all();
    repeat (n) begin
      @(posedge sclk);
      #1;
      check_all();
      @(negedge sclk);
    end
    s_rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_cmd  = CMD_NOP;
    bus.wr_addr = '0;
    bus.wr_bank = '0;
    bus.wr_data = '0;
    bus.rd_cmd  = CMD_NOP;
    bus.rd_addr = '0;
    bus.rd_bank = '0;
    @(negedge sclk);
    apply_reset(3);

    // Init engine drives the bus for 10 cycles
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      cycle();
    end
    bus.flag_init_end = 1'b1;

    // Idle: two refresh rounds
    aref_seen = 0;
    for (int i = 0; i < 1600; i++) begin
      drive(1'b0);
      cycle();
    end
    chk("idle_aref_count", 32'(aref_seen), 32'd2);

    // Refresh pending while both engines ask
    guard = 0;
    while (!pend && guard < 800) begin
      drive(1'b0);
      cycle();
      guard++;
    end
    chk("ref_wait_bound", 32'(guard < 800), 32'd1);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    wr_grants = 0;
    rd_grants = 0;
    aref_seen = 0;
    for (int i = 0; i < 80; i++) begin
      drive(1'b0);
      cycle();
    end
    chk("dir_aref",      32'(aref_seen), 32'd1);
    chk("dir_wr_grants", 32'(wr_grants), 32'd1);
    chk("dir_rd_grants", 32'(rd_grants), 32'd1);

    // Random engine traffic
    for (int i = 0; i < 4000; i++) begin
      drive(1'b1);
      cycle();
    end

    // Reset in the middle of a write
    guard = 0;
    while (owner != M_WR && guard < 500) begin
      drive(1'b1);
      cycle();
      guard++;
    end
    chk("wr_wait_bound", 32'(guard < 500), 32'd1);
    drive(1'b1);
    cycle();
    apply_reset(2);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      cycle();
    end
    bus.flag_init_end = 1'b1;
    aref_seen = 0;
    for (int i = 0; i < 760; i++) begin
      drive(1'b0);
      cycle();
    end
    chk("post_reset_aref", 32'(aref_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
